// File: rtl/pir_sample_filter_pkg.sv
// Shared definitions for the PIR sample filter: control FSM encoding,
// history geometry and averaging constants.
package pir_sample_filter_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } fsm_state_e;

    // Sweep length: 3 channels x 4 history entries, one entry per cycle.
    localparam int CLEAR_CYCLES = 12;

    localparam int NUM_CHAN   = 3;
    localparam int DATA_W     = 7;
    localparam int HIST_DEPTH = 4;
    localparam int HIST_AW    = 2;
    // Average of HIST_DEPTH entries is a right shift by log2(HIST_DEPTH).
    localparam int AVG_SHIFT  = 2;
    // 4 x 127 = 508 fits in 9 bits, so the running sum never overflows.
    localparam int SUM_W      = 9;

endpackage

// File: rtl/pir_chan_avg.sv
// One PIR channel: 4-entry circular history, running sum, warm-up tracking
// and stale timeout. Outputs are registered on the accepting edge.
module pir_chan_avg
    import pir_sample_filter_pkg::*;
#(
    parameter int STALE_CYCLES = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               clr_we_i,
    input  logic [HIST_AW-1:0] clr_idx_i,
    input  logic               sample_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic [DATA_W-1:0]  avg_o,
    output logic               valid_o,
    output logic               stale_o
);

    localparam int SCW = $clog2(STALE_CYCLES + 1);
    localparam int WW  = $clog2(HIST_DEPTH + 1);

    logic [DATA_W-1:0]  hist_q [HIST_DEPTH];

    logic [HIST_AW-1:0] ptr_q, ptr_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [WW-1:0]      warm_q, warm_d;
    logic [SCW-1:0]     scnt_q, scnt_d;
    logic [DATA_W-1:0]  avg_q, avg_d;
    logic               valid_q, valid_d;
    logic               stale_q, stale_d;

    logic               warm_full;
    logic [SUM_W-1:0]   oldest;

    // Next-state for pointer, sum, warm-up, stale counter and the outputs.
    always_comb begin
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        warm_d  = warm_q;
        scnt_d  = scnt_q;
        avg_d   = avg_q;
        valid_d = valid_q;
        stale_d = stale_q;

        warm_full = (warm_q == WW'(HIST_DEPTH));
        // Until the history has been refilled since the last clear or stale
        // event, the slot under the pointer does not belong to the current
        // window (after a timeout it still holds old data), so nothing is
        // subtracted while warming up.
        oldest = warm_full ? SUM_W'(hist_q[ptr_q]) : '0;

        if (clear_i) begin
            ptr_d   = '0;
            sum_d   = '0;
            warm_d  = '0;
            scnt_d  = '0;
            avg_d   = '0;
            valid_d = 1'b0;
            stale_d = 1'b0;
        end else if (sample_i) begin
            // A sample always wins over a timeout reached on the same edge.
            sum_d   = sum_q - oldest + SUM_W'(data_i);
            ptr_d   = ptr_q + HIST_AW'(1);
            warm_d  = warm_full ? warm_q : warm_q + WW'(1);
            scnt_d  = '0;
            stale_d = 1'b0;
            if (warm_d == WW'(HIST_DEPTH)) begin
                avg_d   = DATA_W'(sum_d >> AVG_SHIFT);
                valid_d = 1'b1;
            end else begin
                avg_d   = '0;
                valid_d = 1'b0;
            end
        end else if (scnt_q != SCW'(STALE_CYCLES)) begin
            scnt_d = scnt_q + SCW'(1);
            if (scnt_d == SCW'(STALE_CYCLES)) begin
                stale_d = 1'b1;
                avg_d   = '0;
                valid_d = 1'b0;
                sum_d   = '0;
                warm_d  = '0;
                ptr_d   = '0;
            end
        end
    end

    // History storage: sweep zeroing during clear, otherwise sample writes.
    always_ff @(posedge clk) begin
        if (clr_we_i) begin
            hist_q[clr_idx_i] <= '0;
        end else if (sample_i && !clear_i) begin
            hist_q[ptr_q] <= data_i;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            sum_q   <= '0;
            warm_q  <= '0;
            scnt_q  <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            warm_q  <= warm_d;
            scnt_q  <= scnt_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            stale_q <= stale_d;
        end
    end

    assign avg_o   = avg_q;
    assign valid_o = valid_q;
    assign stale_o = stale_q;

endmodule

// File: rtl/pir_sample_filter.sv
// Three-channel PIR moving-average filter with a CLEAR/RUN control FSM,
// history sweep on entry to CLEAR and a saturating illegal-channel counter.
module pir_sample_filter
    import pir_sample_filter_pkg::*;
#(
    parameter int STALE_CYCLES = 200,
    parameter int CLEAR_CYCLES = pir_sample_filter_pkg::CLEAR_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              turn,
    input  logic              adc_valid,
    output logic              adc_ready,
    input  logic [1:0]        adc_chan,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] pir_sensor_1,
    output logic [DATA_W-1:0] pir_sensor_2,
    output logic [DATA_W-1:0] pir_sensor_3,
    output logic [2:0]        sensor_valid,
    output logic [2:0]        stale,
    output logic [7:0]        drop_count
);

    localparam int SWW = $clog2(CLEAR_CYCLES + 1);

    fsm_state_e         state_q;
    logic [SWW-1:0]     sweep_q;
    logic [7:0]         drop_q;

    logic               accept;
    logic               chan_clear;
    logic [NUM_CHAN-1:0] clr_we;
    logic [DATA_W-1:0]  avg [NUM_CHAN];

    assign adc_ready = (state_q == ST_RUN);
    // turn is qualified here so a sample on the turn-off edge is discarded.
    assign accept    = adc_valid && adc_ready && turn;
    // Channels are zeroed throughout CLEAR and already on the turn-off edge,
    // so the outputs read 0 from the first CLEAR cycle.
    assign chan_clear = (state_q == ST_CLEAR) || !turn;

    // Control FSM: sweep counter, CLEAR/RUN transitions and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
            drop_q  <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (sweep_q == SWW'(CLEAR_CYCLES - 1)) begin
                        if (turn) begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        sweep_q <= sweep_q + SWW'(1);
                    end
                end
                ST_RUN: begin
                    if (!turn) begin
                        state_q <= ST_CLEAR;
                        sweep_q <= '0;
                    end else if (accept && (adc_chan == 2'd0) && (drop_q != 8'hFF)) begin
                        drop_q <= drop_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    sweep_q <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        // Sweep index splits into channel (upper bits) and entry (lower bits).
        assign clr_we[gi] = (state_q == ST_CLEAR) &&
                            ((sweep_q >> HIST_AW) == SWW'(gi));

        pir_chan_avg #(
            .STALE_CYCLES (STALE_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (chan_clear),
            .clr_we_i  (clr_we[gi]),
            .clr_idx_i (sweep_q[HIST_AW-1:0]),
            .sample_i  (accept && (adc_chan == 2'(gi + 1))),
            .data_i    (adc_data),
            .avg_o     (avg[gi]),
            .valid_o   (sensor_valid[gi]),
            .stale_o   (stale[gi])
        );
    end

    assign pir_sensor_1 = avg[0];
    assign pir_sensor_2 = avg[1];
    assign pir_sensor_3 = avg[2];
    assign drop_count   = drop_q;

endmodule
